spwm_gate_monitor: RTL and testbench

SPWM_GATE_MONITOR -- requirements
Module: spwm_gate_monitor

---
 rtl/spwm_gate_monitor.sv | 174 +++++++++++++++++
 tb/tb_spwm_gate_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spwm_gate_monitor.sv
// spwm_gate_monitor: shoot-through / dead-time supervisor on synchronized SPWM gate-pin readback.
// Define SPWM_MON_DEADTIME_CHECK_EN to build the dead-time check; without it only shoot-through is detected.
module spwm_gate_monitor #(
    parameter int unsigned DT_MIN    = 8,
    parameter int unsigned ST_FILT   = 1,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_sel,
    input  logic       enable,
    input  logic       fault_clr,
    input  logic       pin_H,
    input  logic       pin_L,
    input  logic       pin_H1,
    input  logic       pin_L1,
    input  logic       pin_H2,
    input  logic       pin_L2,
    output logic       armed,
    output logic       fault,
    output logic [2:0] fault_leg,
    output logic [1:0] fault_type
);
    typedef enum logic [1:0] {DISARMED, BLANK, ARMED, FAULT} state_t;

    localparam logic [7:0] ST_LIM    = 8'(ST_FILT);
    localparam logic [7:0] BLANK_LIM = 8'(BLANK_CYC);

    state_t     state, next_state;
    logic [2:0] h_s1, h_s2, l_s1, l_s2;
    logic [2:0] ov, st_det, dt_det, det_leg;
    logic [1:0] det_type;
    logic [7:0] st_cnt [3];
    logic [7:0] blank_cnt;
    logic       mode_prev, mode_chg, blank_load;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_s1      <= '0;
            h_s2      <= '0;
            l_s1      <= '0;
            l_s2      <= '0;
            mode_prev <= 1'b0;
        end else begin
            h_s1      <= {pin_H2, pin_H1, pin_H};
            l_s1      <= {pin_L2, pin_L1, pin_L};
            h_s2      <= h_s1;
            l_s2      <= l_s1;
            mode_prev <= mode_sel;
        end
    end

    assign ov       = h_s2 & l_s2;
    assign mode_chg = mode_sel ^ mode_prev;

    // NOTE: the counter arrays are plain flops and are cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) st_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!ov[i])                 st_cnt[i] <= '0;
                else if (st_cnt[i] != ST_LIM) st_cnt[i] <= st_cnt[i] + 8'd1;
            end
        end
    end

    // Detection fires on the edge that would bring the run length up to ST_FILT.
    always_comb begin
        st_det = '0;
        for (int i = 0; i < 3; i++) st_det[i] = ov[i] && (st_cnt[i] >= ST_LIM - 8'd1);
    end

`ifdef SPWM_MON_DEADTIME_CHECK_EN
    localparam logic [7:0] DT_LIM = 8'(DT_MIN);

    logic [2:0] h_prev, l_prev, last_fall_h;
    logic [2:0] h_rise, l_rise, h_fall, l_fall;
    logic [7:0] dt_cnt [3];

    assign h_rise = h_s2 & ~h_prev;
    assign l_rise = l_s2 & ~l_prev;
    assign h_fall = h_prev & ~h_s2;
    assign l_fall = l_prev & ~l_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_prev      <= '0;
            l_prev      <= '0;
            last_fall_h <= '1;
            for (int i = 0; i < 3; i++) dt_cnt[i] <= '0;
        end else begin
            h_prev <= h_s2;
            l_prev <= l_s2;
            for (int i = 0; i < 3; i++) begin
                if (h_fall[i])      last_fall_h[i] <= 1'b1;
                else if (l_fall[i]) last_fall_h[i] <= 1'b0;
                if (h_s2[i] || l_s2[i])       dt_cnt[i] <= '0;
                else if (dt_cnt[i] != DT_LIM) dt_cnt[i] <= dt_cnt[i] + 8'd1;
            end
        end
    end

    // A fall on this very edge counts as the latest fall for the opposite side's rise.
    always_comb begin
        dt_det = '0;
        for (int i = 0; i < 3; i++)
            dt_det[i] = (dt_cnt[i] < DT_LIM) &&
                        ((l_rise[i] && (last_fall_h[i] || h_fall[i])) ||
                         (h_rise[i] && (!last_fall_h[i] || l_fall[i])));
    end
`else
    logic unused_dt_min;
    assign unused_dt_min = ^8'(DT_MIN);
    assign dt_det        = '0;
`endif

    assign det_leg  = st_det | dt_det;
    assign det_type = {|dt_det, |st_det};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DISARMED;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            DISARMED: if (enable) next_state = BLANK;
            BLANK: begin
                if (!enable)              next_state = DISARMED;
                else if (!mode_chg && blank_cnt == 8'd0) next_state = ARMED;
            end
            ARMED: begin
                if (!enable)       next_state = DISARMED;
                else if (mode_chg) next_state = BLANK;
                else if (|det_leg) next_state = FAULT;
            end
            FAULT:   if (fault_clr && ov == 3'b000) next_state = BLANK;
            default: next_state = DISARMED;
        endcase
    end

    always_comb begin
        armed = (state == ARMED);
    end

    // Reload on every entry into BLANK and on a mode change while already blanking.
    assign blank_load = (next_state == BLANK) && ((state != BLANK) || mode_chg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                blank_cnt <= '0;
        else if (blank_load)                       blank_cnt <= BLANK_LIM;
        else if (state == BLANK && blank_cnt != 0) blank_cnt <= blank_cnt - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault      <= 1'b0;
            fault_leg  <= '0;
            fault_type <= '0;
        end else if (state == ARMED && next_state == FAULT) begin
            fault      <= 1'b1;
            fault_leg  <= det_leg;
            fault_type <= det_type;
        end else if (state == FAULT && next_state != FAULT) begin
            fault      <= 1'b0;
            fault_leg  <= '0;
            fault_type <= '0;
        end
    end
endmodule

// File: tb/tb_spwm_gate_monitor.sv
// tb_spwm_gate_monitor: directed scenarios plus random gate activity, compared every clock
// against a rule-level model of the monitor.
module tb_spwm_gate_monitor;
    localparam int DT_MIN    = 4;
    localparam int ST_FILT   = 2;
    localparam int BLANK_CYC = 16;
`ifdef SPWM_MON_DEADTIME_CHECK_EN
    localparam bit DT_ON = 1'b1;
`else
    localparam bit DT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, mode_sel, enable, fault_clr;
    logic [2:0] hh, ll;
    logic       armed, fault;
    logic [2:0] fault_leg;
    logic [1:0] fault_type;
    int         n_checks = 0;
    int         n_fail   = 0;

    spwm_gate_monitor #(.DT_MIN(DT_MIN), .ST_FILT(ST_FILT), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .enable(enable), .fault_clr(fault_clr),
        .pin_H(hh[0]), .pin_L(ll[0]), .pin_H1(hh[1]), .pin_L1(ll[1]), .pin_H2(hh[2]), .pin_L2(ll[2]),
        .armed(armed), .fault(fault), .fault_leg(fault_leg), .fault_type(fault_type)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_out(input logic a, input logic f,
                                             input logic [2:0] lg, input logic [1:0] ty);
        return {25'd0, a, f, lg, ty};
    endfunction

    function automatic logic [31:0] obs();
        return pack_out(armed, fault, fault_leg, fault_type);
    endfunction

    // Reference model: pins become visible two edges after sampling; rules applied per edge.
    typedef enum int {M_DISARMED, M_BLANK, M_ARMED, M_FAULT} m_state_e;
    m_state_e   m_state;
    logic [2:0] d1_h, d1_l, d2_h, d2_l, pv_h, pv_l;
    int         st_run [3];
    int         low_run [3];
    bit         last_h [3];
    logic       m_mode, m_fault;
    logic [2:0] m_leg;
    logic [1:0] m_type;
    int         blank_left;

    task automatic model_reset();
        m_state = M_DISARMED;
        {d1_h, d1_l, d2_h, d2_l, pv_h, pv_l} = '0;
        for (int i = 0; i < 3; i++) begin
            st_run[i] = 0; low_run[i] = 0; last_h[i] = 1'b1;
        end
        m_mode = 1'b0; m_fault = 1'b0; m_leg = '0; m_type = '0; blank_left = 0;
    endtask

    task automatic model_step();
        logic [2:0] sh, sl, ov, hit_st, hit_dt;
        logic       mchg;
        sh = d2_h; sl = d2_l; ov = sh & sl;
        hit_st = '0; hit_dt = '0;
        for (int i = 0; i < 3; i++) begin
            st_run[i] = ov[i] ? ((st_run[i] < 1000) ? st_run[i] + 1 : st_run[i]) : 0;
            hit_st[i] = (st_run[i] >= ST_FILT);
            if (pv_h[i] && !sh[i])      last_h[i] = 1'b1;
            else if (pv_l[i] && !sl[i]) last_h[i] = 1'b0;
            if (DT_ON && low_run[i] < DT_MIN)
                hit_dt[i] = (!pv_l[i] && sl[i] && last_h[i]) || (!pv_h[i] && sh[i] && !last_h[i]);
            low_run[i] = (!sh[i] && !sl[i]) ? ((low_run[i] < DT_MIN) ? low_run[i] + 1 : DT_MIN) : 0;
        end
        mchg = (mode_sel !== m_mode);
        m_mode = mode_sel;
        case (m_state)
            M_DISARMED: if (enable) begin m_state = M_BLANK; blank_left = BLANK_CYC; end
            M_BLANK: begin
                if (!enable)              m_state = M_DISARMED;
                else if (mchg)            blank_left = BLANK_CYC;
                else if (blank_left == 0) m_state = M_ARMED;
                else                      blank_left--;
            end
            M_ARMED: begin
                if (!enable) m_state = M_DISARMED;
                else if (mchg) begin m_state = M_BLANK; blank_left = BLANK_CYC; end
                else if (|(hit_st | hit_dt)) begin
                    m_state = M_FAULT; m_fault = 1'b1;
                    m_leg = hit_st | hit_dt; m_type = {|hit_dt, |hit_st};
                end
            end
            M_FAULT: if (fault_clr && ov == 3'b000) begin
                m_state = M_BLANK; blank_left = BLANK_CYC;
                m_fault = 1'b0; m_leg = '0; m_type = '0;
            end
            default: m_state = M_DISARMED;
        endcase
        pv_h = sh; pv_l = sl;
        d2_h = d1_h; d2_l = d1_l;
        d1_h = hh; d1_l = ll;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("cycle", obs(), pack_out(m_state == M_ARMED, m_fault, m_leg, m_type));
    end

    task automatic drive(input logic [2:0] h, input logic [2:0] l);
        @(negedge clk);
        hh = h; ll = l;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_armed(input string tag, input int budget);
        int c = 0;
        while (armed !== 1'b1 && c < budget) begin @(posedge clk); #2; c++; end
        check(tag, 32'(armed), 32'd1);
    endtask

    task automatic wait_fault(input int budget);
        int c = 0;
        while (fault !== 1'b1 && c < budget) begin @(posedge clk); #2; c++; end
    endtask

    task automatic clear_fault(input string tag);
        int c = 0;
        @(negedge clk);
        hh = '0; ll = '0; fault_clr = 1'b1;
        while (fault !== 1'b0 && c < 10) begin @(posedge clk); #2; c++; end
        check({tag, "_clr"}, 32'(fault), 32'd0);
        @(negedge clk);
        fault_clr = 1'b0;
        wait_armed({tag, "_rearm"}, 40);
    endtask

    int c, first, r_leg, r_sel;

    initial begin
        rst_n = 1'b0; mode_sel = 1'b0; enable = 1'b0; fault_clr = 1'b0; hh = '0; ll = '0;
        idle(3);
        check("reset_outputs", obs(), 32'd0);
        rst_n = 1'b1;
        idle(3);
        check("disarmed_without_enable", obs(), 32'd0);

        // Arming latency: counted from the edge that samples enable.
        enable = 1'b1;
        c = 0;
        while (armed !== 1'b1 && c < 40) begin @(posedge clk); #2; c++; end
        check("arm_latency", 32'(c - 1), 32'd17);
        check("arm_no_fault", 32'(fault), 32'd0);

        // Shoot-through on leg 1 held 5 cycles; edge N is the first sampling edge.
        drive(3'b010, 3'b010);
        first = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #2;
            if (first == 0 && fault === 1'b1) first = i;
        end
        check("st_latency", 32'(first), 32'd4);
        check("st_leg", 32'(fault_leg), 32'd2);
        check("st_type", 32'(fault_type), 32'd1);
        clear_fault("st");

        drive(3'b010, 3'b010);
        drive(3'b000, 3'b000);
        idle(6);
        check("st_glitch_fault", 32'(fault), 32'd0);
        check("st_glitch_armed", 32'(armed), 32'd1);

        // Dead time on leg 0: L rises 2 cycles after H falls (short), then 6 cycles (long).
        drive(3'b001, 3'b000);
        idle(4);
        drive(3'b000, 3'b000);
        idle(1);
        drive(3'b000, 3'b001);
        idle(6);
        check("dt_short_fault", 32'(fault), 32'(DT_ON));
        check("dt_short_leg", 32'(fault_leg), DT_ON ? 32'd1 : 32'd0);
        check("dt_short_type", 32'(fault_type), DT_ON ? 32'd2 : 32'd0);
        clear_fault("dt_short");
        idle(6);
        drive(3'b001, 3'b000);
        idle(4);
        drive(3'b000, 3'b000);
        idle(5);
        drive(3'b000, 3'b001);
        idle(6);
        check("dt_long_fault", 32'(fault), 32'd0);
        drive(3'b000, 3'b000);
        idle(6);

        // Simultaneous overlap on legs 0 and 2.
        drive(3'b101, 3'b101);
        wait_fault(8);
        check("dual_leg", 32'(fault_leg), 32'd5);
        check("dual_type", 32'(fault_type), 32'd1);
        clear_fault("dual");

        // Mode change blanks checking; a late overlap is caught.
        @(negedge clk); mode_sel = 1'b1;
        idle(2);
        drive(3'b010, 3'b010);
        idle(3);
        check("mode_blank_armed", 32'(armed), 32'd0);
        check("mode_blank_fault", 32'(fault), 32'd0);
        drive(3'b000, 3'b000);
        wait_armed("mode_rearm", 40);
        idle(4);
        check("mode_quiet_fault", 32'(fault), 32'd0);
        @(negedge clk); mode_sel = 1'b0;
        idle(20);
        drive(3'b010, 3'b010);
        wait_fault(8);
        check("mode_late_fault", 32'(fault), 32'd1);
        check("mode_late_leg", 32'(fault_leg), 32'd2);

        // Clear is refused while the overlap persists, accepted once it is gone.
        @(negedge clk); fault_clr = 1'b1;
        idle(5);
        check("clr_hold_fault", 32'(fault), 32'd1);
        drive(3'b000, 3'b000);
        c = 0;
        while (fault !== 1'b0 && c < 8) begin @(posedge clk); #2; c++; end
        check("clr_release", obs(), 32'd0);
        @(negedge clk); fault_clr = 1'b0;
        wait_armed("clr_rearm", 40);

        // Asynchronous reset in the middle of a fault.
        drive(3'b100, 3'b100);
        wait_fault(8);
        check("pre_reset_fault", 32'(fault), 32'd1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("rst_mid_fault", obs(), 32'd0);
        hh = '0; ll = '0;
        idle(2);
        rst_n = 1'b1;
        wait_armed("rst_rearm", 40);

        // Random gate activity with sporadic acknowledge; the per-cycle model does the checking.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) begin
                r_leg = $urandom_range(2);
                r_sel = $urandom_range(9);
                hh[r_leg] = (r_sel < 3) || (r_sel == 9);
                ll[r_leg] = (r_sel >= 3 && r_sel < 6) || (r_sel == 9);
            end
            fault_clr = ($urandom_range(7) == 0);
        end
        drive(3'b000, 3'b000);
        fault_clr = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
